// File: rtl/pc_fetch_stage.sv
// Program-counter register and instruction-fetch stage.
// Holds the current PC, issues one instruction-memory request at a time,
// and buffers the returned instruction until decode consumes it.
// A redirect arriving while a request is in flight marks the pending
// response for discard, so stale instructions never reach decode.
module pc_fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned CNT_W    = 32
) (
  input  logic               CLK,
  input  logic               Reset_L,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [63:0]        imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [63:0]        if_pc,
  output logic [INSTR_W-1:0] if_instr,
  input  logic               redirect_valid,
  input  logic [63:0]        redirect_pc,
  output logic               pc_misaligned,
  output logic [CNT_W-1:0]   fetch_count
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [63:0]          pc_reg, pc_next;
  logic                 drop_reg, drop_next;
  logic [63:0]          if_pc_reg, if_pc_next;
  logic [INSTR_W-1:0]   if_instr_reg, if_instr_next;
  logic                 misaligned_reg, misaligned_next;
  logic [CNT_W-1:0]     count_reg, count_next;

  // Redirect target with the low two bits forced to word alignment.
  logic [63:0]          redirect_target;
  logic                 redirect_misaligned;
  logic                 take_redirect;

  assign redirect_target     = {redirect_pc[63:2], 2'b00};
  assign redirect_misaligned = |redirect_pc[1:0];

  // State register and all datapath registers; reset is asynchronous.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_reg      <= S_FETCH;
      pc_reg         <= RESET_PC;
      drop_reg       <= 1'b0;
      if_pc_reg      <= 64'h0;
      if_instr_reg   <= '0;
      misaligned_reg <= 1'b0;
      count_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      drop_reg       <= drop_next;
      if_pc_reg      <= if_pc_next;
      if_instr_reg   <= if_instr_next;
      misaligned_reg <= misaligned_next;
      count_reg      <= count_next;
    end
  end

  // Next-state and next-datapath logic for the fetch sequencer.
  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    drop_next       = drop_reg;
    if_pc_next      = if_pc_reg;
    if_instr_next   = if_instr_reg;
    misaligned_next = misaligned_reg;
    count_next      = count_reg;
    take_redirect   = 1'b0;

    case (state_reg)
      S_FETCH: begin
        take_redirect = redirect_valid;
        if (imem_req_ready) begin
          state_next = S_WAIT;
          // A redirect during the handshake makes the in-flight response stale.
          drop_next  = redirect_valid;
        end
      end
      S_WAIT: begin
        take_redirect = redirect_valid;
        if (imem_rsp_valid) begin
          if (!drop_reg && !redirect_valid) begin
            if_instr_next = imem_rdata;
            if_pc_next    = pc_reg;
            state_next    = S_VALID;
          end else begin
            drop_next  = 1'b0;
            state_next = S_FETCH;
          end
        end else if (redirect_valid) begin
          drop_next = 1'b1;
        end
      end
      S_VALID: begin
        take_redirect = redirect_valid;
        if (if_ready) begin
          count_next = count_reg + CNT_W'(1);
          state_next = S_FETCH;
          if (!redirect_valid) begin
            pc_next = pc_reg + 64'd4;
          end
        end else if (redirect_valid) begin
          // Squash the buffered instruction without counting it.
          state_next = S_FETCH;
        end
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase

    if (take_redirect) begin
      pc_next = redirect_target;
      if (redirect_misaligned) begin
        misaligned_next = 1'b1;
      end
    end
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    imem_req_valid = 1'b0;
    if_valid       = 1'b0;
    case (state_reg)
      S_FETCH: imem_req_valid = 1'b1;
      S_VALID: if_valid       = 1'b1;
      default: begin
        imem_req_valid = 1'b0;
        if_valid       = 1'b0;
      end
    endcase
  end

  assign imem_addr     = pc_reg;
  assign if_pc         = if_pc_reg;
  assign if_instr      = if_instr_reg;
  assign pc_misaligned = misaligned_reg;
  assign fetch_count   = count_reg;

endmodule
